// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-write scoreboard for ID hazard stalls
module rf_scoreboard #(
   parameter int CNT_W = 2,
   parameter int NREG  = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            id_valid,
   input  logic [4:0]      id_rs1,
   input  logic            id_rs1_en,
   input  logic [4:0]      id_rs2,
   input  logic            id_rs2_en,
   input  logic [4:0]      id_rd,
   input  logic            id_rd_we,
   input  logic            id_fire,
   input  logic            wb_valid,
   input  logic            wb_we,
   input  logic [4:0]      wb_waddr,
   output logic            id_stall,
   output logic [NREG-1:0] busy_vec,
   output logic [5:0]      inflight,
   output logic            sb_err
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   logic [CNT_W-1:0] cnt_q [NREG];
   logic [CNT_W-1:0] cnt_d [NREG];
   logic [5:0]       inflight_q, inflight_d;
   logic             err_q, err_d;

   logic issue, retire, same_reg;
   logic issue_sat, retire_unf;
   logic issue_app, retire_app;
   logic raw_rs1, raw_rs2, rd_full;

   // Register 0 is excluded here, so its counter can never leave zero.
   assign issue    = id_fire & id_rd_we & (id_rd != 5'd0);
   assign retire   = wb_valid & wb_we & (wb_waddr != 5'd0);

   // Issue and retire on the same register cancel out, including at the
   // counter limits, so neither an error nor a change is produced.
   assign same_reg   = issue & retire & (id_rd == wb_waddr);
   assign issue_sat  = issue & ~same_reg & (cnt_q[id_rd] == CNT_MAX);
   assign retire_unf = retire & ~same_reg & (cnt_q[wb_waddr] == CNT_ZERO);
   assign issue_app  = issue & ~same_reg & ~issue_sat;
   assign retire_app = retire & ~same_reg & ~retire_unf;

   // Hazard detection uses registered counters only; a retire in this cycle
   // releases the stall next cycle because there is no WB-to-ID bypass.
   assign raw_rs1  = id_rs1_en & (id_rs1 != 5'd0) & (cnt_q[id_rs1] != CNT_ZERO);
   assign raw_rs2  = id_rs2_en & (id_rs2 != 5'd0) & (cnt_q[id_rs2] != CNT_ZERO);
   assign rd_full  = id_rd_we & (id_rd != 5'd0) & (cnt_q[id_rd] == CNT_MAX);
   assign id_stall = id_valid & (raw_rs1 | raw_rs2 | rd_full);

   // Busy flags mirror the counters; bit 0 is hard-wired low.
   always_comb begin
      busy_vec = '0;
      for (int i = 1; i < NREG; i++) begin
         busy_vec[i] = (cnt_q[i] != CNT_ZERO);
      end
   end

   assign inflight = inflight_q;
   assign sb_err   = err_q;

   // Next-state: flush wins over issue/retire; errors are sticky and only
   // recorded on cycles that actually update counters.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      inflight_d = inflight_q;
      err_d      = err_q;
      if (flush) begin
         for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = CNT_ZERO;
         end
         inflight_d = 6'd0;
      end else begin
         if (issue_app) begin
            cnt_d[id_rd] = cnt_q[id_rd] + 1'b1;
         end
         if (retire_app) begin
            cnt_d[wb_waddr] = cnt_q[wb_waddr] - 1'b1;
         end
         inflight_d = inflight_q + {5'd0, issue_app} - {5'd0, retire_app};
         err_d      = err_q | issue_sat | retire_unf;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= CNT_ZERO;
         end
         inflight_q <= 6'd0;
         err_q      <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb/tb_rf_scoreboard.sv - self-checking bench for rf_scoreboard
module tb_rf_scoreboard;

   localparam int CNT_MAX = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        id_valid = 1'b0;
   logic [4:0]  id_rs1 = '0;
   logic        id_rs1_en = 1'b0;
   logic [4:0]  id_rs2 = '0;
   logic        id_rs2_en = 1'b0;
   logic [4:0]  id_rd = '0;
   logic        id_rd_we = 1'b0;
   logic        id_fire = 1'b0;
   logic        wb_valid = 1'b0;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_waddr = '0;
   logic        id_stall;
   logic [31:0] busy_vec;
   logic [5:0]  inflight;
   logic        sb_err;

   int n_checks = 0;
   int n_fail   = 0;
   int m_cnt [32];
   int m_err;

   rf_scoreboard #(.CNT_W(2), .NREG(32)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_en(id_rs1_en),
      .id_rs2(id_rs2), .id_rs2_en(id_rs2_en), .id_rd(id_rd), .id_rd_we(id_rd_we),
      .id_fire(id_fire), .wb_valid(wb_valid), .wb_we(wb_we), .wb_waddr(wb_waddr),
      .id_stall(id_stall), .busy_vec(busy_vec), .inflight(inflight), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
   endfunction

   function automatic logic exp_stall();
      if (!id_valid) return 1'b0;
      if (id_rs1_en && id_rs1 != 0 && m_cnt[id_rs1] > 0) return 1'b1;
      if (id_rs2_en && id_rs2 != 0 && m_cnt[id_rs2] > 0) return 1'b1;
      if (id_rd_we && id_rd != 0 && m_cnt[id_rd] == CNT_MAX) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] exp_busy();
      logic [31:0] b = '0;
      for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
      return b;
   endfunction

   function automatic int exp_sum();
      int s = 0;
      for (int i = 0; i < 32; i++) s += m_cnt[i];
      return s % 64;
   endfunction

   function automatic void model_step();
      logic iss, ret;
      iss = id_fire && id_rd_we && id_rd != 0;
      ret = wb_valid && wb_we && wb_waddr != 0;
      if (flush) begin
         model_clear();
         return;
      end
      if (iss && ret && id_rd == wb_waddr) return;
      if (iss) begin
         if (m_cnt[id_rd] == CNT_MAX) m_err = 1;
         else m_cnt[id_rd]++;
      end
      if (ret) begin
         if (m_cnt[wb_waddr] == 0) m_err = 1;
         else m_cnt[wb_waddr]--;
      end
   endfunction

   // Called at posedge+1: check the combinational stall, clock once, check state.
   task automatic tick();
      #1 check("stall", id_stall, exp_stall());
      @(posedge clk);
      model_step();
      #1;
      check("busy", busy_vec, exp_busy());
      check("inflight", inflight, exp_sum());
      check("err", sb_err, m_err);
   endtask

   task automatic idle();
      flush = 0; id_valid = 0; id_rs1_en = 0; id_rs2_en = 0; id_rd_we = 0;
      id_fire = 0; wb_valid = 0; wb_we = 0;
      id_rs1 = 0; id_rs2 = 0; id_rd = 0; wb_waddr = 0;
   endtask

   task automatic issue(input logic [4:0] rd);
      idle();
      id_valid = 1; id_rd = rd; id_rd_we = 1; id_fire = 1;
      tick();
   endtask

   task automatic retire(input logic [4:0] wa);
      idle();
      wb_valid = 1; wb_we = 1; wb_waddr = wa;
      tick();
   endtask

   initial begin
      model_clear();
      m_err = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy_vec, 32'd0);
      check("rst_inflight", inflight, 6'd0);
      check("rst_err", sb_err, 1'b0);
      reset = 0;

      // RAW stall and one-cycle-late release
      issue(5'd3);
      idle(); id_valid = 1; id_rs1 = 3; id_rs1_en = 1;
      #1 check("raw_stall", id_stall, 1'b1);
      tick();
      wb_valid = 1; wb_we = 1; wb_waddr = 3;
      #1 check("raw_stall_wb_cycle", id_stall, 1'b1);
      tick();
      wb_valid = 0; wb_we = 0;
      #1 check("raw_release", id_stall, 1'b0);
      tick();

      // simultaneous issue and retire on reg 7
      issue(5'd7);
      idle(); id_valid = 1; id_rd = 7; id_rd_we = 1; id_fire = 1;
      wb_valid = 1; wb_we = 1; wb_waddr = 7;
      tick();
      check("same_reg_busy7", busy_vec[7], 1'b1);
      check("same_reg_inflight", inflight, 6'd1);
      retire(5'd7);

      // saturation on reg 9
      issue(5'd9); issue(5'd9); issue(5'd9);
      idle(); id_valid = 1; id_rd = 9; id_rd_we = 1;
      #1 check("sat_stall", id_stall, 1'b1);
      tick();
      id_fire = 1;
      tick();
      check("sat_err", sb_err, 1'b1);
      check("sat_inflight", inflight, 6'd3);

      // underflow and register 0
      reset = 1; #1 reset = 0; model_clear(); m_err = 0;
      retire(5'd4);
      check("unf_err", sb_err, 1'b1);
      check("unf_busy", busy_vec, 32'd0);
      idle(); id_valid = 1; id_rs1 = 0; id_rs1_en = 1; id_rd = 0; id_rd_we = 1; id_fire = 1;
      wb_valid = 1; wb_we = 1; wb_waddr = 0;
      #1 check("r0_stall", id_stall, 1'b0);
      tick();
      check("r0_inflight", inflight, 6'd0);

      // flush overrides a same-cycle issue
      issue(5'd1); issue(5'd2); issue(5'd31);
      idle(); flush = 1; id_valid = 1; id_rd = 6; id_rd_we = 1; id_fire = 1;
      tick();
      check("flush_busy", busy_vec, 32'd0);
      check("flush_inflight", inflight, 6'd0);
      check("flush_err_kept", sb_err, 1'b1);

      // asynchronous reset mid-stream
      issue(5'd5); issue(5'd5);
      idle();
      #2 reset = 1;
      #1;
      check("arst_busy", busy_vec, 32'd0);
      check("arst_inflight", inflight, 6'd0);
      check("arst_err", sb_err, 1'b0);
      model_clear(); m_err = 0;
      @(posedge clk); #1 reset = 0;

      // randomized legal traffic against the model
      for (int n = 0; n < 3000; n++) begin
         idle();
         id_valid  = 1'($urandom_range(0, 3) != 0);
         id_rs1    = 5'($urandom); id_rs1_en = 1'($urandom);
         id_rs2    = 5'($urandom); id_rs2_en = 1'($urandom);
         id_rd     = 5'($urandom_range(0, 12));
         id_rd_we  = 1'($urandom);
         id_fire   = id_valid && !exp_stall() && ($urandom_range(0, 2) != 0);
         wb_valid  = 1'($urandom);
         wb_we     = 1'($urandom_range(0, 3) != 0);
         wb_waddr  = 5'($urandom_range(0, 12));
         if (wb_valid && wb_we && wb_waddr != 0 && m_cnt[wb_waddr] == 0 &&
             !(id_fire && id_rd_we && id_rd == wb_waddr))
            wb_we = 0;
         flush     = ($urandom_range(0, 99) == 0);
         tick();
      end
      check("rand_err_clean", sb_err, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
